// File: rtl/writeback_unit.sv
// Write-back stage: accepts ALU and load results through valid/ready handshakes,
// queues them in order, and drives the register file write port one write per
// cycle. A pending-write scoreboard lets decode stall on results not yet landed.
module writeback_unit #(
    parameter int WORD_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [REG_ADDR_WIDTH-1:0]     alu_addr,
    input  logic [WORD_WIDTH-1:0]         alu_data,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [REG_ADDR_WIDTH-1:0]     mem_addr,
    input  logic [WORD_WIDTH-1:0]         mem_data,
    input  logic                          wb_hold,
    output logic                          rf_write_en,
    output logic [REG_ADDR_WIDTH-1:0]     rf_write_addr,
    output logic [WORD_WIDTH-1:0]         rf_write_data,
    input  logic [REG_ADDR_WIDTH-1:0]     chk_addr1,
    input  logic [REG_ADDR_WIDTH-1:0]     chk_addr2,
    output logic                          chk_pending1,
    output logic                          chk_pending2,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          idle
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [PTR_W-1:0]          r_wptr;
    logic [PTR_W-1:0]          r_rptr;
    logic [CNT_W-1:0]          r_count;
    logic [FIFO_DEPTH-1:0]     r_valid;
    logic [REG_ADDR_WIDTH-1:0] r_addr [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0]     r_data [FIFO_DEPTH];

    logic                      w_full;
    logic                      w_acc_mem;
    logic                      w_acc_alu;
    logic [REG_ADDR_WIDTH-1:0] w_in_addr;
    logic [WORD_WIDTH-1:0]     w_in_data;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_hit1;
    logic                      w_hit2;

    // Readies depend only on registered occupancy and mem_valid; memory wins ties.
    assign w_full    = (r_count == FULL_CNT);
    assign mem_ready = !w_full;
    assign alu_ready = !w_full && !mem_valid;
    assign w_acc_mem = mem_valid && mem_ready;
    assign w_acc_alu = alu_valid && alu_ready;
    assign w_in_addr = w_acc_mem ? mem_addr : alu_addr;
    assign w_in_data = w_acc_mem ? mem_data : alu_data;

    // Writes to R0 complete the handshake but are dropped here.
    assign w_push = (w_acc_mem || w_acc_alu) && (w_in_addr != '0);
    // Occupancy is registered, so a push into an empty queue cannot pop the same cycle.
    assign w_pop  = (r_count != '0) && !wb_hold;

    assign fifo_count = r_count;
    assign idle       = (r_count == '0) && !rf_write_en;

    // Queue control state: pointers, occupancy and per-entry valid flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_pop) begin
                r_rptr          <= r_rptr + PTR_W'(1);
                r_valid[r_rptr] <= 1'b0;
            end
            if (w_push) begin
                r_wptr          <= r_wptr + PTR_W'(1);
                r_valid[r_wptr] <= 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Entry payload storage; only meaningful where the valid flag is set.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wptr] <= w_in_addr;
            r_data[r_wptr] <= w_in_data;
        end
    end

    // Register-file write port: pop the head, otherwise drop enable and hold addr/data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_write_en   <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
        end else begin
            rf_write_en <= w_pop;
            if (w_pop) begin
                rf_write_addr <= r_addr[r_rptr];
                rf_write_data <= r_data[r_rptr];
            end
        end
    end

    // Scoreboard: match check addresses against queued entries and the in-flight write.
    always_comb begin
        w_hit1 = rf_write_en && (rf_write_addr == chk_addr1);
        w_hit2 = rf_write_en && (rf_write_addr == chk_addr2);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == chk_addr1)) w_hit1 = 1'b1;
            if (r_valid[i] && (r_addr[i] == chk_addr2)) w_hit2 = 1'b1;
        end
        chk_pending1 = w_hit1 && (chk_addr1 != '0);
        chk_pending2 = w_hit2 && (chk_addr2 != '0);
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-back stage for the 16-bit, 16-register CPU core. Accepts completed results from the ALU path and the load (memory) path through valid/ready handshakes, queues them in order in a small FIFO, and drives the register file's single synchronous write port one write per cycle. Provides a pending-write scoreboard so decode can stall on operands whose write-back has not yet landed.

## Interface

**Parameters**
- `WORD_WIDTH`, 16: data width.
- `REG_ADDR_WIDTH`, 4: register address width.
- `FIFO_DEPTH`, 4: queue entries; a power of two, at least 2.

**Ports**
- `clk` in 1: single clock; all state is on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `alu_valid` in 1: ALU result offered.
- `alu_ready` out 1: ALU result accepted this cycle when `alu_valid` is also high.
- `alu_addr` in `REG_ADDR_WIDTH`: destination register.
- `alu_data` in `WORD_WIDTH`: result.
- `mem_valid` in 1: load result offered.
- `mem_ready` out 1: load result accepted this cycle when `mem_valid` is also high.
- `mem_addr` in `REG_ADDR_WIDTH`: destination register.
- `mem_data` in `WORD_WIDTH`: load data.
- `wb_hold` in 1: suspends dequeue, for example while the write port is borrowed.
- `rf_write_en` out 1: register-file write enable (registered).
- `rf_write_addr` out `REG_ADDR_WIDTH`: register-file write address (registered).
- `rf_write_data` out `WORD_WIDTH`: register-file write data (registered).
- `chk_addr1` in `REG_ADDR_WIDTH`: first operand address to check.
- `chk_addr2` in `REG_ADDR_WIDTH`: second operand address to check.
- `chk_pending1` out 1: a write to `chk_addr1` is queued or in flight.
- `chk_pending2` out 1: a write to `chk_addr2` is queued or in flight.
- `fifo_count` out `$clog2(FIFO_DEPTH)+1`: current occupancy.
- `idle` out 1: FIFO empty and `rf_write_en` low.

## Operation

**Acceptance**
- At most one result is accepted per cycle; memory has fixed priority.
- `mem_ready = (fifo_count != FIFO_DEPTH)`.
- `alu_ready = (fifo_count != FIFO_DEPTH) && !mem_valid`.
- Both ready outputs depend only on registered occupancy and `mem_valid`. There is no pop-through when full.
- An accepted result whose address is 0 completes the handshake normally but is discarded. It is not enqueued, occupancy does not change, and R0 is never written.

**Queue**
- Circular FIFO with write and read pointers that wrap modulo `FIFO_DEPTH`.
- Order of acceptance is preserved. When two writes target the same register, the later one reaches the register file later, so the later one wins.

**Dequeue**
- Each cycle the FIFO is non-empty and `wb_hold` is low, the head is popped into the output registers and `rf_write_en` is set to 1.
- Otherwise `rf_write_en` is set to 0, and `rf_write_addr`/`rf_write_data` hold their last values.

**Simultaneous events**
- Push and pop in the same cycle leave `fifo_count` unchanged and advance both pointers.
- A push into an empty FIFO cannot pop in the same cycle. The entry appears at the head on the next cycle.

**Scoreboard**
- `chk_pendingN = (chk_addrN != 0) && (any valid FIFO entry has addr == chk_addrN, or (rf_write_en && rf_write_addr == chk_addrN))`.
- Combinational from registered state only. An incoming, not-yet-accepted result is not counted.

**Reset**
- Asserting `rst` mid-operation drops every queued write and any in-flight `rf_write_en`.

## Timing

- **Reset values:** `rf_write_en=0`, `rf_write_addr=0`, `rf_write_data=0`, `fifo_count=0`, pointers 0, `chk_pending1/2=0`, `idle=1`, `alu_ready=mem_ready=1` (`alu_ready` is 0 if `mem_valid` is high).
- **Latency:** accepted at edge E, popped at edge E+1, so `rf_write_en` is high between E+1 and E+2, and the register file captures the write at E+2. Minimum 2 edges from acceptance to register update, assuming an empty FIFO and `wb_hold` low.
- **Scoreboard window:** `chk_pending` rises after E and falls after E+2. It covers exactly the window in which a register-file read would return stale data.
- **Throughput:** one write per cycle sustained.
- **Holding:** with `wb_hold` high, occupancy grows by one per accepted result until `FIFO_DEPTH`, then both readies drop.

## Test plan

1. **Reset.** Pull `rst` low asynchronously mid-cycle with 3 entries queued and `rf_write_en` high. Required: outputs take their reset values immediately; after release, `idle=1`, and none of the 3 writes ever appears.
2. **Single ALU write.** `alu_valid=1`, `alu_addr=3`, `alu_data=0x1234` for one cycle (edge E). Required: `rf_write_en=1`, addr 3, data 0x1234 for exactly one cycle after E+1; `chk_pending` for addr 3 is high from after E until after E+2; then `idle=1`.
3. **Priority.** `mem_valid` (addr 5, 0xAAAA) and `alu_valid` (addr 6, 0x5555) in the same cycle. Required: `alu_ready=0`; mem is accepted; ALU is accepted the next cycle; write-backs appear in order 5:0xAAAA then 6:0x5555 on consecutive cycles.
4. **Full.** `wb_hold=1`; push 4 ALU results (addrs 1–4, data 0x0011–0x0044). Required: `fifo_count` reaches 4 and both readies drop to 0. Release hold: 4 writes drain in order on 4 consecutive cycles, readies rise after the first pop, and a new push during the drain lands behind them.
5. **R0 discard.** ALU write to addr 0 with data 0xFFFF. Required: handshake completes, `fifo_count` stays 0, `rf_write_en` never rises, and `chk_pending` with `chk_addr=0` stays 0.
6. **Same-address ordering and wrap.** 10 back-to-back writes to addr 7 with data 1..10, toggling `wb_hold` to force pointer wrap. Required: write-backs appear as 1..10 in order, the last `rf_write_data` is 10, and `chk_pending1` (`chk_addr1=7`) deasserts only after the final write.
